dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipelined core's MEM stage and a debug/program-loader requester.
- Sits between the EM pipeline boundary and the data memory.
- The core has priority by default. A starvation counter guarantees the debug port progress. A lock mode gives the debug port exclusive burst ownership.
- The core is back-pressured through C_STALL, which the pipeline uses to freeze the EM/MW boundaries.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, data width.
- MAX_WAIT, 8, maximum number of consecutive cycles debug may wait while core holds the port; must be >= 1.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- C_REQ  in  1  core MEM-stage access request (EM_MEMRD | EM_MEMWRT).
- C_WE  in  1  core write (1) / read (0).
- C_FUNC3  in  3  core access size/sign (load/store funct3).
- C_ADDR  in  ADDR_W  core byte address.
- C_WDATA  in  DATA_W  core store data.
- C_RDATA  out  DATA_W  core load data; combinational copy of M_RDATA.
- C_STALL  out  1  core request not served this cycle.
- D_REQ  in  1  debug access request.
- D_WE  in  1  debug write/read.
- D_LOCK  in  1  debug requests exclusive ownership.
- D_ADDR  in  ADDR_W  debug word address (funct3 forced to word, 3'b010).
- D_WDATA  in  DATA_W  debug write data.
- D_GNT  out  1  debug access performed this cycle.
- D_RVALID  out  1  registered: D_RDATA valid, one cycle after a read grant.
- D_RDATA  out  DATA_W  registered debug read data.
- M_RD, M_WRT  out  1 each  memory read/write strobes.
- M_FUNC3  out  3  memory access size.
- M_ADDR  out  ADDR_W  memory address.
- M_WDATA  out  DATA_W  memory write data.
- M_RDATA  in  DATA_W  memory read data (combinational read, synchronous write).

Behaviour:
- States: OWN_CORE, OWN_DBG_LOCK. Reset state OWN_CORE, wait_cnt=0, D_RVALID=0, D_RDATA=0.
- While RESET_N=0, D_GNT, C_STALL, M_RD and M_WRT are all forced to 0.
- Debug grant, OWN_CORE: dbg_win = D_REQ & (~C_REQ | wait_cnt==MAX_WAIT).
- Debug grant, OWN_DBG_LOCK: dbg_win = D_REQ.
- Outputs: D_GNT = dbg_win.
- C_STALL = C_REQ & (dbg_win | state==OWN_DBG_LOCK). A core request is never served in OWN_DBG_LOCK, even with D_REQ low.
- Memory mux when dbg_win: debug fields drive the port, with M_RD = ~D_WE and M_WRT = D_WE.
- Memory mux otherwise: core fields drive the port, with strobes gated by C_REQ and ~C_STALL.
- Idle port: M_RD = M_WRT = 0; address and data follow the core fields.
- wait_cnt in OWN_CORE:
  - Increments when D_REQ & C_REQ & ~dbg_win, saturating at MAX_WAIT.
  - Clears to 0 on dbg_win or ~D_REQ.
  - Width is clog2(MAX_WAIT+1).
- Transitions:
  - OWN_CORE -> OWN_DBG_LOCK when dbg_win & D_LOCK. The grant cycle itself is already a debug access.
  - OWN_DBG_LOCK -> OWN_CORE when D_LOCK=0, sampled at the clock edge. In that same cycle dbg_win is still evaluated with lock rules.
- Read return: if dbg_win & ~D_WE, then D_RVALID<=1 and D_RDATA<=M_RDATA on the next edge; else D_RVALID<=0. D_RDATA holds its value otherwise.
- Core reads are zero-latency: C_RDATA = M_RDATA in the served cycle.
- The core holds C_* stable while C_STALL=1.
- Debug holds its request until D_GNT. D_REQ dropping before grant is legal and clears wait_cnt.
- Simultaneous requests with wait_cnt<MAX_WAIT: core wins. With wait_cnt==MAX_WAIT: debug wins once and the counter clears, so the core is served next cycle unless D_LOCK=1.
- Asynchronous reset mid-lock or mid-read: immediate return to OWN_CORE; a pending D_RVALID is dropped; nothing is written to memory.
- No X propagation: all outputs are defined in every state.

Decomposition:
- Shared package/define file:
  - State encodings OWN_CORE=1'b0, OWN_DBG_LOCK=1'b1.
  - FUNC3_WORD=3'b010.
  - Alongside the existing ALUSRC/control constants.
- One natural sub-module: dmem_arb_wait_ctr, the saturating starvation counter (inputs inc, clr; output sat). The FSM and mux stay in the top.

Test Plan:
- Reset: hold RESET_N=0 with C_REQ=D_REQ=1 -> D_GNT=0, C_STALL=0, M_RD=M_WRT=0, D_RVALID=0; release -> state OWN_CORE.
- Debug-only read: C_REQ=0, D_REQ=1, D_WE=0, D_ADDR=0x100, memory word 0xDEADBEEF -> D_GNT=1 in the same cycle, M_FUNC3=3'b010; next cycle D_RVALID=1, D_RDATA=0xDEADBEEF.
- Starvation with MAX_WAIT=8: C_REQ=1 and D_REQ=1 continuously -> C_STALL=0 for 8 cycles; cycle 9 D_GNT=1 and C_STALL=1; cycle 10 core served again.
- Lock burst: D_LOCK=1 with 4 debug writes to 0x200..0x20C, C_REQ=1 throughout -> C_STALL=1 for all 4 cycles plus any D_REQ=0 gap cycles; drop D_LOCK -> C_STALL=0 one cycle later; readback returns written values.
- Core store/load passthrough: C_WE=1, C_FUNC3=3'b000, C_ADDR=0x3, C_WDATA=0xAB, then load from the same address -> M_WRT then M_RD strobes, C_RDATA low byte 0xAB in the load cycle, C_STALL=0.
- Reset mid-lock: assert RESET_N=0 during OWN_DBG_LOCK with a read granted -> D_RVALID stays 0; after release, C_REQ=1 alone -> C_STALL=0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared encodings for the data-memory port arbiter and core control
package dmem_port_arbiter_pkg;

    // Port ownership states
    localparam logic OWN_CORE     = 1'b0;
    localparam logic OWN_DBG_LOCK = 1'b1;

    // Load/store funct3 encodings
    localparam logic [2:0] FUNC3_BYTE  = 3'b000;
    localparam logic [2:0] FUNC3_HALF  = 3'b001;
    localparam logic [2:0] FUNC3_WORD  = 3'b010;
    localparam logic [2:0] FUNC3_BYTEU = 3'b100;
    localparam logic [2:0] FUNC3_HALFU = 3'b101;

    // ALU operand-B source select
    typedef enum logic {
        ALUSRC_REG = 1'b0,
        ALUSRC_IMM = 1'b1
    } alusrc_e;

    // Result writeback source select
    typedef enum logic [1:0] {
        WBSRC_ALU = 2'b00,
        WBSRC_MEM = 2'b01,
        WBSRC_PC4 = 2'b10
    } wbsrc_e;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// rtl/dmem_arb_wait_ctr.sv - saturating count of cycles the debug requester has been kept waiting
module dmem_arb_wait_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX_WAIT);

    logic [W-1:0] cnt;

    // Clear wins over increment so a grant always restarts the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == MAX_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data-memory port between the core MEM stage and the debug loader
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              C_REQ,
    input  logic              C_WE,
    input  logic [2:0]        C_FUNC3,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    output logic [DATA_W-1:0] C_RDATA,
    output logic              C_STALL,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic              D_LOCK,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              M_RD,
    output logic              M_WRT,
    output logic [2:0]        M_FUNC3,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    input  logic [DATA_W-1:0] M_RDATA
);

    logic state;
    logic state_nxt;
    logic starved;
    logic dbg_win;
    logic core_go;
    logic locked;

    assign locked = (state == OWN_DBG_LOCK);

    // Every grant and strobe is qualified by RESET_N so nothing escapes while reset is asserted
    assign dbg_win = RESET_N & D_REQ & (locked | ~C_REQ | starved);
    assign C_STALL = RESET_N & C_REQ & (dbg_win | locked);
    assign core_go = RESET_N & C_REQ & ~C_STALL;
    assign D_GNT   = dbg_win;
    assign C_RDATA = M_RDATA;

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (CLK),
        .rst_n (RESET_N),
        .inc   (D_REQ & C_REQ & ~dbg_win),
        .clr   (dbg_win | ~D_REQ),
        .sat   (starved)
    );

    always_comb begin
        M_RD    = 1'b0;
        M_WRT   = 1'b0;
        M_FUNC3 = C_FUNC3;
        M_ADDR  = C_ADDR;
        M_WDATA = C_WDATA;
        if (dbg_win) begin
            M_RD    = ~D_WE;
            M_WRT   = D_WE;
            M_FUNC3 = FUNC3_WORD;
            M_ADDR  = D_ADDR;
            M_WDATA = D_WDATA;
        end else begin
            M_RD    = core_go & ~C_WE;
            M_WRT   = core_go & C_WE;
        end
    end

    // Leaving the lock takes effect at the edge; the release cycle still arbitrates under lock rules
    always_comb begin
        state_nxt = state;
        case (state)
            OWN_CORE:     if (dbg_win && D_LOCK) state_nxt = OWN_DBG_LOCK;
            OWN_DBG_LOCK: if (!D_LOCK) state_nxt = OWN_CORE;
            default:      state_nxt = OWN_CORE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= OWN_CORE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            D_RVALID <= 1'b0;
            D_RDATA  <= '0;
        end else begin
            D_RVALID <= dbg_win & ~D_WE;
            if (dbg_win && !D_WE) begin
                D_RDATA <= M_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for the data-memory port arbiter
module tb_dmem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        C_REQ, C_WE;
    logic [2:0]  C_FUNC3;
    logic [31:0] C_ADDR, C_WDATA, C_RDATA;
    logic        C_STALL;
    logic        D_REQ, D_WE, D_LOCK;
    logic [31:0] D_ADDR, D_WDATA;
    logic        D_GNT, D_RVALID;
    logic [31:0] D_RDATA;
    logic        M_RD, M_WRT;
    logic [2:0]  M_FUNC3;
    logic [31:0] M_ADDR, M_WDATA, M_RDATA;

    typedef struct packed {
        logic        rd;
        logic        wrt;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] rd_q[$];
    int          total = 0;
    int          fails = 0;

    always #5 CLK = ~CLK;

    dmem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (8)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .C_REQ    (C_REQ),
        .C_WE     (C_WE),
        .C_FUNC3  (C_FUNC3),
        .C_ADDR   (C_ADDR),
        .C_WDATA  (C_WDATA),
        .C_RDATA  (C_RDATA),
        .C_STALL  (C_STALL),
        .D_REQ    (D_REQ),
        .D_WE     (D_WE),
        .D_LOCK   (D_LOCK),
        .D_ADDR   (D_ADDR),
        .D_WDATA  (D_WDATA),
        .D_GNT    (D_GNT),
        .D_RVALID (D_RVALID),
        .D_RDATA  (D_RDATA),
        .M_RD     (M_RD),
        .M_WRT    (M_WRT),
        .M_FUNC3  (M_FUNC3),
        .M_ADDR   (M_ADDR),
        .M_WDATA  (M_WDATA),
        .M_RDATA  (M_RDATA)
    );

    // Data memory: combinational sized read, synchronous sized write, preloaded during reset
    logic [31:0] mem [0:1023];
    logic [31:0] rd_word, rd_shift;

    always_comb begin
        rd_word  = mem[M_ADDR[11:2]];
        rd_shift = rd_word >> {M_ADDR[1:0], 3'b000};
        case (M_FUNC3)
            3'b000:  M_RDATA = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  M_RDATA = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  M_RDATA = {24'h0, rd_shift[7:0]};
            3'b101:  M_RDATA = {16'h0, rd_shift[15:0]};
            default: M_RDATA = rd_word;
        endcase
    end

    always @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[10'h040] <= 32'hDEAD_BEEF;
            mem[10'h041] <= 32'h1234_5678;
        end else if (M_WRT) begin
            case (M_FUNC3)
                3'b000:  mem[M_ADDR[11:2]][{M_ADDR[1:0], 3'b000} +: 8] <= M_WDATA[7:0];
                3'b001:  mem[M_ADDR[11:2]][{M_ADDR[1], 4'b0000} +: 16] <= M_WDATA[15:0];
                default: mem[M_ADDR[11:2]] <= M_WDATA;
            endcase
        end
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; expected port access and read return go to the scoreboard queues
    task automatic step(input logic eg, input logic es, input logic [31:0] erd);
        acc_t a;
        if (eg) begin
            a = '{rd: ~D_WE, wrt: D_WE, f3: 3'b010, addr: D_ADDR, wdata: D_WDATA};
            acc_q.push_back(a);
            if (!D_WE) rd_q.push_back(erd);
        end else if (C_REQ && !es) begin
            a = '{rd: ~C_WE, wrt: C_WE, f3: C_FUNC3, addr: C_ADDR, wdata: C_WDATA};
            acc_q.push_back(a);
        end
        @(negedge CLK);
        check("d_gnt", {71'h0, D_GNT}, {71'h0, eg});
        check("c_stall", {71'h0, C_STALL}, {71'h0, es});
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares every memory access and every debug read return as the DUT presents them
    always @(negedge CLK) begin
        acc_t g;
        acc_t e;
        if (acc_q.size() > 0 || M_RD || M_WRT) begin
            g = '{rd: M_RD, wrt: M_WRT, f3: M_FUNC3, addr: M_ADDR, wdata: M_WDATA};
            e = '0;
            if (acc_q.size() > 0) e = acc_q.pop_front();
            check("mem_access", {3'b0, g}, {3'b0, e});
        end
        if (D_RVALID) begin
            if (rd_q.size() == 0) check("d_rvalid_unexpected", 72'h1, 72'h0);
            else check("d_rdata", {40'h0, D_RDATA}, {40'h0, rd_q.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        acc_t a;
        RESET_N = 1'b0;
        C_REQ = 1'b1; C_WE = 1'b0; C_FUNC3 = 3'b010; C_ADDR = 32'h100; C_WDATA = 32'h0;
        D_REQ = 1'b1; D_WE = 1'b0; D_LOCK = 1'b1; D_ADDR = 32'h104; D_WDATA = 32'h0;

        // Reset holds every grant and strobe low
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_d_gnt", {71'h0, D_GNT}, 72'h0);
        check("rst_c_stall", {71'h0, C_STALL}, 72'h0);
        check("rst_m_rd", {71'h0, M_RD}, 72'h0);
        check("rst_m_wrt", {71'h0, M_WRT}, 72'h0);
        check("rst_d_rvalid", {71'h0, D_RVALID}, 72'h0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1; D_REQ = 1'b0; D_LOCK = 1'b0;
        step(1'b0, 1'b0, 32'h0);

        // Debug-only read
        C_REQ = 1'b0; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h100;
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        D_REQ = 1'b0;
        step(1'b0, 1'b0, 32'h0);

        // Starvation: core served 8 cycles, debug wins the 9th, core back on the 10th
        C_REQ = 1'b1; D_REQ = 1'b1; D_ADDR = 32'h104;
        repeat (8) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h1234_5678);
        step(1'b0, 1'b0, 32'h0);
        D_REQ = 1'b0; C_REQ = 1'b0;
        step(1'b0, 1'b0, 32'h0);

        // Lock burst under continuous core pressure
        C_REQ = 1'b1; D_REQ = 1'b1; D_LOCK = 1'b1; D_WE = 1'b1;
        D_ADDR = 32'h200; D_WDATA = 32'hA000_0000;
        repeat (8) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0);
        D_ADDR = 32'h204; D_WDATA = 32'hA000_0001;
        step(1'b1, 1'b1, 32'h0);
        D_REQ = 1'b0;
        step(1'b0, 1'b1, 32'h0);
        D_REQ = 1'b1; D_ADDR = 32'h208; D_WDATA = 32'hA000_0002;
        step(1'b1, 1'b1, 32'h0);
        D_ADDR = 32'h20C; D_WDATA = 32'hA000_0003;
        step(1'b1, 1'b1, 32'h0);
        D_WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            D_ADDR = 32'h200 + 32'(4 * i);
            step(1'b1, 1'b1, 32'hA000_0000 + 32'(i));
        end
        D_REQ = 1'b0; D_LOCK = 1'b0;
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        C_REQ = 1'b0;
        step(1'b0, 1'b0, 32'h0);

        // Core byte store then signed and unsigned byte loads
        C_REQ = 1'b1; C_WE = 1'b1; C_FUNC3 = 3'b000; C_ADDR = 32'h3; C_WDATA = 32'hAB;
        step(1'b0, 1'b0, 32'h0);
        C_WE = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        check("c_rdata_lb", {40'h0, C_RDATA}, {40'h0, 32'hFFFF_FFAB});
        C_FUNC3 = 3'b100;
        step(1'b0, 1'b0, 32'h0);
        check("c_rdata_lbu", {40'h0, C_RDATA}, {40'h0, 32'h0000_00AB});

        // Reset during a locked read grant
        C_REQ = 1'b0; D_REQ = 1'b1; D_LOCK = 1'b1; D_WE = 1'b1;
        D_ADDR = 32'h210; D_WDATA = 32'h55;
        step(1'b1, 1'b0, 32'h0);
        C_REQ = 1'b1; C_FUNC3 = 3'b010; C_ADDR = 32'h100;
        D_WE = 1'b0; D_ADDR = 32'h200;
        a = '{rd: 1'b1, wrt: 1'b0, f3: 3'b010, addr: 32'h200, wdata: 32'h55};
        acc_q.push_back(a);
        @(negedge CLK);
        check("lockrd_d_gnt", {71'h0, D_GNT}, 72'h1);
        check("lockrd_c_stall", {71'h0, C_STALL}, 72'h1);
        #2;
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_d_rvalid", {71'h0, D_RVALID}, 72'h0);
        check("midrst_d_gnt", {71'h0, D_GNT}, 72'h0);
        check("midrst_c_stall", {71'h0, C_STALL}, 72'h0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1; D_REQ = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        C_REQ = 1'b0; D_LOCK = 1'b0;
        step(1'b0, 1'b0, 32'h0);

        @(negedge CLK);
        check("acc_q_drained", 72'(acc_q.size()), 72'h0);
        check("rd_q_drained", 72'(rd_q.size()), 72'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end

endmodule
